// File: rtl/dma_resp_pkg.sv
// Shared types and constants for the DMA BRAM responder.
// Line/count widths here match the responder's default parameters.
package dma_resp_pkg;

  localparam int unsigned LINE_WIDTH      = 512;
  localparam int unsigned COUNT_WIDTH     = 43;
  localparam int unsigned LINE_BYTES_LOG2 = $clog2(LINE_WIDTH / 8);

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_DRAIN,
    RD_DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACCEPT,
    WR_DONE
  } wr_state_t;

endpackage

// File: rtl/dma_sc_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and single-cycle flush.
// dout reads as zero whenever the FIFO is empty.
module dma_sc_fifo #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dma_bram_responder.sv
// Responder side of the mem_ctrl DMA interface, backed by an inferred
// simple dual-port RAM (port A: read engine, port B: write engine).
module dma_bram_responder
  import dma_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LINE_WIDTH,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned SIZE_WIDTH = COUNT_WIDTH,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  input  logic                  wr_go,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  wr_done,
  output logic                  host_wr_completed,
  output logic                  wr_overflow
);

  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam int unsigned BYTE_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  // ---------------- read engine ----------------
  rd_state_t             rd_state, rd_state_nx;
  logic [IDX_W-1:0]      rd_idx;
  logic [SIZE_WIDTH-1:0] rd_size_q, rd_issued, rd_popped;
  logic                  rd_inflight;
  logic                  rd_issue, rd_pop;
  logic [CNT_W-1:0]      rd_fifo_count;
  logic                  rd_fifo_full;
  logic [CNT_W:0]        rd_occ;

  // Occupancy includes the line still in the RAM pipeline so the FIFO never overruns.
  always_comb begin
    rd_occ   = {1'b0, rd_fifo_count} + (CNT_W + 1)'(rd_inflight);
    rd_issue = (rd_state == RD_FETCH) && !rd_go && (rd_issued < rd_size_q)
               && (rd_occ < (CNT_W + 1)'(FIFO_DEPTH));
    rd_pop   = rd_en && !empty && !rd_go;
  end

  always_comb begin
    rd_state_nx = rd_state;
    if (rd_go) begin
      rd_state_nx = (rd_size == '0) ? RD_DONE : RD_FETCH;
    end else begin
      case (rd_state)
        RD_FETCH: if (rd_issue && (rd_issued + 1'b1 == rd_size_q)) rd_state_nx = RD_DRAIN;
        RD_DRAIN: if (rd_pop && (rd_popped + 1'b1 == rd_size_q))   rd_state_nx = RD_DONE;
        default:  rd_state_nx = rd_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state    <= RD_IDLE;
      rd_idx      <= '0;
      rd_size_q   <= '0;
      rd_issued   <= '0;
      rd_popped   <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_state <= rd_state_nx;
      if (rd_go) begin
        rd_idx      <= rd_addr[BYTE_LSB +: IDX_W];
        rd_size_q   <= rd_size;
        rd_issued   <= '0;
        rd_popped   <= '0;
        rd_inflight <= 1'b0;
      end else begin
        rd_inflight <= rd_issue;
        if (rd_issue) begin
          rd_idx    <= rd_idx + 1'b1;
          rd_issued <= rd_issued + 1'b1;
        end
        if (rd_pop) rd_popped <= rd_popped + 1'b1;
      end
    end
  end

  assign rd_done = (rd_state == RD_DONE);

  dma_sc_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (rd_go),
    .push  (rd_inflight),
    .pop   (rd_pop),
    .din   (ram_q),
    .dout  (rd_data),
    .empty (empty),
    .full  (rd_fifo_full),
    .count (rd_fifo_count)
  );

  // ---------------- write engine ----------------
  wr_state_t             wr_state, wr_state_nx;
  logic [IDX_W-1:0]      wr_idx;
  logic [SIZE_WIDTH-1:0] wr_size_q, wr_pushed, wr_written;
  logic                  wr_accept, wr_push, wr_drop, wr_commit;
  logic                  wr_fifo_empty;
  logic [DATA_WIDTH-1:0] wr_fifo_dout;
  logic [CNT_W-1:0]      wr_fifo_count;

  always_comb begin
    wr_accept = (wr_state == WR_ACCEPT) && (wr_pushed < wr_size_q);
    wr_push   = wr_en && !wr_go && !full && wr_accept;
    wr_drop   = wr_en && !wr_go && (full || !wr_accept);
    wr_commit = (wr_state == WR_ACCEPT) && !wr_go && !wr_fifo_empty;
  end

  always_comb begin
    wr_state_nx = wr_state;
    if (wr_go) begin
      wr_state_nx = (wr_size == '0) ? WR_DONE : WR_ACCEPT;
    end else if ((wr_state == WR_ACCEPT) && wr_commit && (wr_written + 1'b1 == wr_size_q)) begin
      wr_state_nx = WR_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state    <= WR_IDLE;
      wr_idx      <= '0;
      wr_size_q   <= '0;
      wr_pushed   <= '0;
      wr_written  <= '0;
      wr_overflow <= 1'b0;
    end else begin
      wr_state <= wr_state_nx;
      if (wr_drop) wr_overflow <= 1'b1;
      if (wr_go) begin
        wr_idx     <= wr_addr[BYTE_LSB +: IDX_W];
        wr_size_q  <= wr_size;
        wr_pushed  <= '0;
        wr_written <= '0;
      end else begin
        if (wr_push) wr_pushed <= wr_pushed + 1'b1;
        if (wr_commit) begin
          wr_idx     <= wr_idx + 1'b1;
          wr_written <= wr_written + 1'b1;
        end
      end
    end
  end

  assign wr_done           = (wr_state == WR_DONE);
  assign host_wr_completed = wr_done;

  dma_sc_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (wr_go),
    .push  (wr_push),
    .pop   (wr_commit),
    .din   (wr_data),
    .dout  (wr_fifo_dout),
    .empty (wr_fifo_empty),
    .full  (full),
    .count (wr_fifo_count)
  );

  // Same-index collision returns the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (wr_commit) ram[wr_idx] <= wr_fifo_dout;
    if (rd_issue)  ram_q <= ram[rd_idx];
  end

  logic unused_ok;
  assign unused_ok = ^{rd_addr, wr_addr, rd_fifo_full, wr_fifo_count};

endmodule

// File: tb/tb_dma_bram_responder.sv
// Directed/randomized bench for dma_bram_responder against a line-array memory model.
module tb_dma_bram_responder;

  localparam int unsigned DW    = 512;
  localparam int unsigned AW    = 64;
  localparam int unsigned SW    = 43;
  localparam int unsigned DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_go, rd_en, wr_go, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [SW-1:0] rd_size, wr_size;
  logic [DW-1:0] rd_data, wr_data;
  logic          empty, rd_done, full, wr_done, host_wr_completed, wr_overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] model_ram [DEPTH];

  always #5 clk = ~clk;

  dma_bram_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SIZE_WIDTH (SW),
    .MEM_DEPTH  (DEPTH),
    .FIFO_DEPTH (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rd_go             (rd_go),
    .rd_addr           (rd_addr),
    .rd_size           (rd_size),
    .rd_en             (rd_en),
    .rd_data           (rd_data),
    .empty             (empty),
    .rd_done           (rd_done),
    .wr_go             (wr_go),
    .wr_addr           (wr_addr),
    .wr_size           (wr_size),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .full              (full),
    .wr_done           (wr_done),
    .host_wr_completed (host_wr_completed),
    .wr_overflow       (wr_overflow)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] l;
    for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int line_index(input logic [AW-1:0] addr);
    return int'((addr / 64) % DEPTH);
  endfunction

  // Back-to-back pushes; the model records only the first 'size' lines.
  task automatic do_write(input logic [AW-1:0] addr, input int size, input int extra, input string tag);
    int idx = line_index(addr);
    int cnt;
    logic [DW-1:0] line;
    wr_go = 1'b1; wr_addr = addr; wr_size = SW'(size);
    @(negedge clk);
    wr_go = 1'b0;
    chk1({tag, "_done_clr"}, wr_done, 1'b0);
    for (int i = 0; i < size + extra; i++) begin
      line = rand_line();
      wr_en = 1'b1; wr_data = line;
      if (i < size) model_ram[(idx + i) % DEPTH] = line;
      @(negedge clk);
      chk1({tag, "_full"}, full, 1'b0);
    end
    wr_en = 1'b0;
    if (extra == 0) begin
      chk1({tag, "_done_early"}, wr_done, 1'b0);
      @(negedge clk);
      chk1({tag, "_done"}, wr_done, 1'b1);
    end else begin
      cnt = 0;
      while (!wr_done && cnt < 50) begin @(negedge clk); cnt++; end
      chk1({tag, "_done"}, wr_done, 1'b1);
    end
    chk1({tag, "_hwc"}, host_wr_completed, 1'b1);
  endtask

  // Start a read, optionally stall 'hold' cycles, then pop randomly and compare.
  task automatic do_read(input logic [AW-1:0] addr, input int size, input int hold,
                         input int prob, input string tag);
    logic [DW-1:0] exp_q[$];
    int idx = line_index(addr);
    int cnt;
    logic en;
    for (int i = 0; i < size; i++) exp_q.push_back(model_ram[(idx + i) % DEPTH]);
    rd_go = 1'b1; rd_addr = addr; rd_size = SW'(size); rd_en = 1'b0;
    @(negedge clk);
    rd_go = 1'b0;
    chk1({tag, "_done_clr"}, rd_done, 1'b0);
    for (int i = 0; i < hold; i++) @(negedge clk);
    if (hold > 0) chk1({tag, "_held_nonempty"}, empty, 1'b0);
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 1000) begin
      en = ($urandom_range(0, 99) < prob);
      if (en && !empty) chkl({tag, "_data"}, rd_data, exp_q.pop_front());
      rd_en = en;
      @(negedge clk);
      cnt++;
    end
    rd_en = 1'b0;
    chki({tag, "_remaining"}, exp_q.size(), 0);
    chk1({tag, "_done"}, rd_done, 1'b1);
    chk1({tag, "_empty_end"}, empty, 1'b1);
  endtask

  logic [DW-1:0] a_lines [4];
  logic [DW-1:0] keep_line;

  initial begin
    rst_n = 1'b0;
    rd_go = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_size = '0;
    wr_go = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_size = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk1("rst_rd_done", rd_done, 1'b0);
    chk1("rst_wr_done", wr_done, 1'b0);
    chk1("rst_hwc", host_wr_completed, 1'b0);
    chk1("rst_ovf", wr_overflow, 1'b0);
    chkl("rst_rd_data", rd_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: four-line write at line 0
    do_write(64'h0, 4, 0, "t1");
    for (int i = 0; i < 4; i++) a_lines[i] = model_ram[i];

    // 2: exact-latency read with rd_en held
    rd_go = 1'b1; rd_addr = '0; rd_size = SW'(4);
    @(negedge clk);
    rd_go = 1'b0; rd_en = 1'b1;
    chk1("t2_empty_t1", empty, 1'b1);
    @(negedge clk);
    chk1("t2_empty_t2", empty, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t2_nonempty", empty, 1'b0);
      chkl("t2_data", rd_data, a_lines[i]);
    end
    @(negedge clk);
    rd_en = 1'b0;
    chk1("t2_done", rd_done, 1'b1);
    chk1("t2_empty_end", empty, 1'b1);

    // 3: 20-line read that stalls on a full FIFO, then random pops
    do_write(64'(100 * 64), 20, 0, "t3w");
    do_read(64'(100 * 64), 20, 20, 60, "t3r");

    // 4: wraparound write; address high bits and byte offset must be ignored
    do_write(64'hABCD_0000_0000_0000 | 64'((DEPTH - 2) * 64) | 64'h15, 4, 0, "t4w");
    do_read(64'((DEPTH - 2) * 64), 2, 0, 100, "t4hi");
    do_read(64'h0, 2, 0, 100, "t4lo");

    // go while busy: abort a long read and restart at line 100
    rd_go = 1'b1; rd_addr = 64'(300 * 64); rd_size = SW'(10);
    @(negedge clk);
    rd_go = 1'b0;
    repeat (4) @(negedge clk);
    do_read(64'(100 * 64), 6, 0, 80, "tab");

    // 5: zero-size transfers
    rd_go = 1'b1; rd_addr = 64'(100 * 64); rd_size = '0;
    @(negedge clk);
    rd_go = 1'b0;
    chk1("t5_rd_done", rd_done, 1'b1);
    repeat (3) @(negedge clk);
    chk1("t5_empty", empty, 1'b1);
    wr_go = 1'b1; wr_addr = 64'(100 * 64); wr_size = '0;
    @(negedge clk);
    wr_go = 1'b0;
    chk1("t5_wr_done", wr_done, 1'b1);
    chk1("t5_hwc", host_wr_completed, 1'b1);
    repeat (2) @(negedge clk);
    do_read(64'(100 * 64), 1, 0, 100, "t5r");

    // overflow: one push beyond wr_size must be dropped and flagged
    do_write(64'(200 * 64), 3, 0, "tovp");
    keep_line = model_ram[202];
    chk1("tov_pre", wr_overflow, 1'b0);
    do_write(64'(200 * 64), 2, 1, "tov");
    chk1("tov_flag", wr_overflow, 1'b1);
    do_read(64'(200 * 64), 3, 0, 100, "tovr");
    chkl("tov_keep", model_ram[202], keep_line);

    // 6: async reset with the read FIFO five deep
    rd_go = 1'b1; rd_addr = 64'(100 * 64); rd_size = SW'(12); rd_en = 1'b0;
    @(negedge clk);
    rd_go = 1'b0;
    repeat (6) @(negedge clk);
    chk1("t6_pre_empty", empty, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_empty", empty, 1'b1);
    chk1("t6_rd_done", rd_done, 1'b0);
    chkl("t6_rd_data", rd_data, '0);
    chk1("t6_wr_done", wr_done, 1'b0);
    chk1("t6_ovf_clr", wr_overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(64'(100 * 64), 12, 3, 70, "t6r");
    chk1("t6_ovf_stays", wr_overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
